// File: rtl/clock_div_checker.sv
// Divided-clock monitor: synchronizes div_in, measures half-periods, and tracks lock.
// Ports: clk, rst, div_in, enable, clear_err -> rise_pulse, fall_pulse, half_len, locked, err.
module clock_div_checker #(
  parameter int HALF_PERIOD = 5,
  parameter int TOL         = 0,
  parameter int LOCK_COUNT  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       div_in,
  input  logic       enable,
  input  logic       clear_err,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [7:0] half_len,
  output logic       locked,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE, ACQUIRE, TRACK, LOCKED
  } state_t;

  localparam int LO_I  = (HALF_PERIOD > TOL) ? HALF_PERIOD - TOL : 0;
  localparam int HI_I  = HALF_PERIOD + TOL;
  localparam int TMO_I = (2 * HALF_PERIOD > 255) ? 255 : 2 * HALF_PERIOD;

  localparam logic [8:0] LO9  = LO_I[8:0];
  localparam logic [8:0] HI9  = HI_I[8:0];
  localparam logic [7:0] TMO8 = TMO_I[7:0];
  localparam logic [7:0] LC8  = LOCK_COUNT[7:0];

  state_t     state_q, state_d;
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q, prev_d;
  logic [2:0] vld_q, vld_d;
  logic       rise_e_q, rise_e_d;
  logic       fall_e_q, fall_e_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] good_q, good_d;
  logic [7:0] half_len_q, half_len_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic       locked_q, locked_d;
  logic       err_q, err_d;

  logic       edge_s;
  logic       act;
  logic       tmo;
  logic       good;
  logic [7:0] meas;
  logic [7:0] good_inc;
  logic       err_set;

  assign edge_s   = rise_e_q | fall_e_q;
  assign act      = enable && (state_q != IDLE);
  assign tmo      = !edge_s && (cnt_q == TMO8);
  assign meas     = (cnt_q == 8'hff) ? 8'hff : cnt_q + 8'd1;
  assign good     = ({1'b0, meas} >= LO9) && ({1'b0, meas} <= HI9);
  assign good_inc = good_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = ACQUIRE;
        ACQUIRE: if (edge_s) state_d = TRACK;
        TRACK: begin
          if (edge_s && good && (good_inc >= LC8)) state_d = LOCKED;
          else if (tmo)                            state_d = ACQUIRE;
        end
        LOCKED: begin
          if (edge_s && !good) state_d = TRACK;
          else if (tmo)        state_d = ACQUIRE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sync1_d    = div_in;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    // prev must hold a real sample before edges count, so a high
    // div_in at reset release does not look like a rising edge
    vld_d      = {vld_q[1:0], 1'b1};
    rise_e_d   = vld_q[2] & sync2_q & ~prev_q;
    fall_e_d   = vld_q[2] & ~sync2_q & prev_q;
    rise_d     = act & rise_e_q;
    fall_d     = act & fall_e_q;
    cnt_d      = cnt_q;
    good_d     = good_q;
    half_len_d = half_len_q;
    err_set    = 1'b0;
    if (!act) begin
      cnt_d  = 8'd0;
      good_d = 8'd0;
    end else begin
      if (edge_s)                cnt_d = 8'd0;
      else if (cnt_q != 8'hff)   cnt_d = cnt_q + 8'd1;
      unique case (state_q)
        TRACK: begin
          if (edge_s) begin
            half_len_d = meas;
            good_d     = good ? good_inc : 8'd0;
          end else if (tmo) begin
            good_d = 8'd0;
          end
        end
        LOCKED: begin
          if (edge_s) half_len_d = meas;
          if ((edge_s && !good) || tmo) begin
            good_d  = 8'd0;
            err_set = 1'b1;
          end
        end
        default: good_d = 8'd0;
      endcase
    end
    if (err_set)        err_d = 1'b1;
    else if (clear_err) err_d = 1'b0;
    else                err_d = err_q;
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      vld_q      <= 3'b000;
      rise_e_q   <= 1'b0;
      fall_e_q   <= 1'b0;
      cnt_q      <= 8'd0;
      good_q     <= 8'd0;
      half_len_q <= 8'd0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      vld_q      <= vld_d;
      rise_e_q   <= rise_e_d;
      fall_e_q   <= fall_e_d;
      cnt_q      <= cnt_d;
      good_q     <= good_d;
      half_len_q <= half_len_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign half_len   = half_len_q;
  assign locked     = locked_q;
  assign err        = err_q;

endmodule

// File: tb/tb_clock_div_checker.sv
// Directed bench for clock_div_checker: lock, stretch, timeout, clear_err,
// enable, reset and a TOL=1 instance.
module tb_clock_div_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       div_in;
  logic       clear_err;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] half_len;
  logic       locked;
  logic       err;

  logic       div2;
  logic       clear2;
  logic       t_rise;
  logic       t_fall;
  logic [7:0] t_half;
  logic       t_locked;
  logic       t_err;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  clock_div_checker dut (
    .clk(clk), .rst(rst), .div_in(div_in), .enable(enable),
    .clear_err(clear_err), .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse), .half_len(half_len),
    .locked(locked), .err(err)
  );

  clock_div_checker #(.HALF_PERIOD(5), .TOL(1), .LOCK_COUNT(4)) dut_t (
    .clk(clk), .rst(rst), .div_in(div2), .enable(enable),
    .clear_err(clear2), .rise_pulse(t_rise),
    .fall_pulse(t_fall), .half_len(t_half),
    .locked(t_locked), .err(t_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int c);
    while (cyc < c) begin
      tick();
      cyc++;
    end
  endtask

  logic spur;

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    div_in    = 1'b0;
    clear_err = 1'b0;
    div2      = 1'b0;
    clear2    = 1'b0;
    #2;
    chk("rst_rise",   rise_pulse, 0);
    chk("rst_fall",   fall_pulse, 0);
    chk("rst_half",   half_len,   0);
    chk("rst_locked", locked,     0);
    chk("rst_err",    err,        0);
    repeat (3) tick();
    rst    = 1'b0;
    enable = 1'b1;
    repeat (5) tick();

    cyc = 0;
    div_in = 1'b1;
    go(3);   chk("lat_early",   rise_pulse, 0);
    go(4);   chk("lat_rise",    rise_pulse, 1);
             chk("acq_half",    half_len,   0);
             chk("acq_locked",  locked,     0);
    go(5);   chk("lat_1cyc",    rise_pulse, 0);
             div_in = ~div_in;
    go(10);  div_in = ~div_in;
    go(15);  div_in = ~div_in;
    go(20);  div_in = ~div_in;
    go(23);  chk("lock_early",  locked,     0);
    go(24);  chk("lock",        locked,     1);
             chk("lock_half",   half_len,   5);
             chk("lock_err",    err,        0);
    go(27);  div_in = ~div_in;
    go(31);  chk("str_half",    half_len,   7);
             chk("str_locked",  locked,     0);
             chk("str_err",     err,        1);
    go(32);  div_in = ~div_in;
    go(37);  div_in = ~div_in;
    go(42);  div_in = ~div_in;
    go(47);  div_in = ~div_in;
    go(51);  chk("relock",      locked,     1);
             chk("relock_err",  err,        1);
             chk("relock_half", half_len,   5);
             chk("fall_pulse",  fall_pulse, 1);
             chk("no_rise",     rise_pulse, 0);
    go(52);  div_in = ~div_in;
    go(60);  div_in = ~div_in;
    go(63);  clear_err = 1'b1;
    go(64);  chk("clr_same",    err,        1);
             chk("bad_unlock",  locked,     0);
    go(65);  clear_err = 1'b0;
             chk("clr_alone",   err,        0);
    go(66);  div_in = ~div_in;
    go(71);  div_in = ~div_in;
    go(76);  div_in = ~div_in;
    go(81);  div_in = ~div_in;
    go(86);  div_in = ~div_in;
    go(90);  chk("lock3",       locked,     1);
             chk("lock3_err",   err,        0);
    go(100); chk("tmo_early",   locked,     1);
    go(101); chk("tmo_locked",  locked,     0);
             chk("tmo_err",     err,        1);
    go(103); div_in = ~div_in;
    go(107); chk("acq_fall",    fall_pulse, 1);
             chk("acq_keep",    half_len,   5);
             chk("acq_nolock",  locked,     0);
    go(108); div_in = ~div_in;
    go(113); div_in = ~div_in;
    go(118); div_in = ~div_in;
    go(123); div_in = ~div_in;
    go(127); chk("lock4",       locked,     1);
             enable = 1'b0;
    go(128); chk("dis_locked",  locked,     0);
             chk("dis_err",     err,        1);
             chk("dis_half",    half_len,   5);
    go(129); div_in = ~div_in;
    go(133); chk("idle_pulse",  rise_pulse | fall_pulse, 0);
    go(135); enable = 1'b1;
    go(140); div_in = ~div_in;
    go(145); div_in = ~div_in;
    go(150); div_in = ~div_in;
    go(155); div_in = ~div_in;
    go(160); div_in = ~div_in;
    go(164); chk("lock5",       locked,     1);
    go(166);
    #2;
    rst    = 1'b1;
    div_in = 1'b1;
    #1;
    chk("mid_rise",   rise_pulse, 0);
    chk("mid_fall",   fall_pulse, 0);
    chk("mid_half",   half_len,   0);
    chk("mid_locked", locked,     0);
    chk("mid_err",    err,        0);
    repeat (2) tick();
    rst  = 1'b0;
    spur = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      spur = spur | rise_pulse | fall_pulse;
    end
    chk("rel_spur",   spur,     0);
    chk("rel_locked", locked,   0);
    chk("rel_half",   half_len, 0);

    cyc = 0;
    div2 = ~div2;
    go(4);   div2 = ~div2;
    go(10);  div2 = ~div2;
    go(14);  div2 = ~div2;
    go(20);  div2 = ~div2;
    go(23);  chk("tol_early",   t_locked, 0);
    go(24);  chk("tol_lock",    t_locked, 1);
             chk("tol_half",    t_half,   6);
    go(27);  div2 = ~div2;
    go(31);  chk("tol_bad",     t_locked, 0);
             chk("tol_err",     t_err,    1);
             chk("tol_half7",   t_half,   7);
    go(32);  div2 = ~div2;
    go(36);  div2 = ~div2;
    go(42);  div2 = ~div2;
    go(46);  div2 = ~div2;
    go(49);  chk("tol_gc_clr",  t_locked, 0);
    go(50);  chk("tol_relock",  t_locked, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/clock_div_checker.md
CLOCK_DIV_CHECKER -- requirements
Module: clock_div_checker

Interface
REQ-001 Parameter HALF_PERIOD, default 5: expected fast-clock cycles between consecutive edges of the monitored divided clock.
REQ-002 Parameter TOL, default 0: allowed deviation, in cycles, of a measured half-period from HALF_PERIOD.
REQ-003 Parameter LOCK_COUNT, default 4: consecutive good half-periods required to declare lock.
REQ-004 Port clk  input  1  system clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port div_in  input  1  divided clock under test; asynchronous to logic, treated as data.
REQ-007 Port enable  input  1  monitor enable; low forces IDLE.
REQ-008 Port clear_err  input  1  single-cycle request to clear sticky err.
REQ-009 Port rise_pulse  output  1  one-cycle pulse per detected rising edge of div_in.
REQ-010 Port fall_pulse  output  1  one-cycle pulse per detected falling edge of div_in.
REQ-011 Port half_len  output  8  last measured half-period in clk cycles.
REQ-012 Port locked  output  1  high while in LOCKED state.
REQ-013 Port err  output  1  sticky: set on loss of lock from LOCKED.

Function
REQ-014 div_in SHALL pass a 2-flop synchronizer followed by a previous-value flop; edge = sync XOR prev.
REQ-015 div_in value first sampled at edge N SHALL produce rise_pulse/fall_pulse high during exactly the cycle after edge N+3 (registered outputs).
REQ-016 Pulses SHALL be generated whenever enable is high, in all states except IDLE.
REQ-017 Interval counter cnt (8 bits) SHALL clear to 0 on a detected edge, else increment, saturating at 255.
REQ-018 On a detected edge, measured = cnt+1 (saturating at 255); half_len SHALL update with measured except on the first edge after entering ACQUIRE.
REQ-019 Edge is good when |measured - HALF_PERIOD| <= TOL, else bad.
REQ-020 Timeout SHALL occur when cnt reaches 2*HALF_PERIOD with no edge.
REQ-021 States: IDLE, ACQUIRE, TRACK, LOCKED; counter good_cnt tracks consecutive good edges.
REQ-022 IDLE -> ACQUIRE when enable=1; cnt and good_cnt cleared in IDLE.
REQ-023 ACQUIRE -> TRACK on first detected edge (not graded); good_cnt=0.
REQ-024 TRACK: good edge increments good_cnt; when good_cnt reaches LOCK_COUNT -> LOCKED in same transition; bad edge clears good_cnt, stay TRACK; timeout -> ACQUIRE.
REQ-025 LOCKED: good edge stays; bad edge -> TRACK with good_cnt=0, err set; timeout -> ACQUIRE, err set.
REQ-026 enable=0 in any state -> IDLE next cycle; err retained.
REQ-027 clear_err clears err next cycle; if an err-setting event occurs same cycle, err SHALL remain 1.
REQ-028 locked SHALL be registered and equal (state==LOCKED).

Reset
REQ-029 rst=1 SHALL immediately force: state IDLE, synchronizer/prev flops 0, cnt 0, good_cnt 0, half_len 0, rise_pulse 0, fall_pulse 0, locked 0, err 0.
REQ-030 rst asserted mid-operation SHALL discard all state; after release, first edge re-enters ACQUIRE path (no stale lock or spurious pulse from div_in=1 at release until an actual transition is synchronized).

Verification
REQ-031 Defaults, enable=1, div_in toggling every 5 clks -> half_len=5, locked=1 after 5th detected edge (1 acquire + 4 good), err=0.
REQ-032 Locked, one half-period stretched to 7 clks -> half_len=7, locked=0, err=1, relock after 4 further good edges; err stays 1.
REQ-033 Locked, div_in held constant -> timeout at cnt=10, state ACQUIRE, locked=0, err=1; rise/fall pulses stop.
REQ-034 clear_err pulsed in same cycle as a bad edge in LOCKED -> err=1; clear_err alone next cycle -> err=0.
REQ-035 TOL=1, half-periods alternating 4 and 6 -> all good, locked=1; a 7 -> bad edge, good_cnt=0.
REQ-036 rst asserted while locked -> all outputs 0 same cycle; enable=0 while locked -> IDLE, locked=0, err unchanged.
